// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Definitions shared by the fetch PC unit, its skid register and the bench.
//   - fetch_state_t     : buffering state of the fetch stage
//   - PC_STEP           : byte distance between sequential instructions
//   - DEFAULT_NOP_INSTR : bubble word presented when nothing valid is held
// ---------------------------------------------------------------------------
package fetch_pkg;

    // IDLE : nothing buffered, no ROM response in flight
    // RESP : the synchronous ROM is returning a valid word this cycle
    // HELD : the presented word sits in the skid register
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HELD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP           = 32'd4;

    // Bubble encoding: op = 2'b00, inst = 2'b10.
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h2000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_if
//   Bundles the control inputs, instruction-ROM port and presented-instruction
//   outputs of fetch_pc_unit.
//   master : the fetch unit itself (drives ROM address and presented word)
//   slave  : the surroundings (pipeline control, ROM, decode stage)
//
//   stall_i    downstream does not accept the presented instruction
//   jmp_en     one-cycle redirect request
//   jmp_target redirect byte address
//   imem_addr  ROM address (ROM has one cycle of read latency)
//   imem_rdata ROM data for the address presented in the previous cycle
//   curr_pc    byte address of the presented instruction
//   ACIns      presented instruction word
//   ins_valid  curr_pc/ACIns carry a real instruction
//   flush_out  squash pulse toward the fetch pipeline register
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if;

    logic        stall_i;
    logic        jmp_en;
    logic [31:0] jmp_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] curr_pc;
    logic [31:0] ACIns;
    logic        ins_valid;
    logic        flush_out;

    modport master (
        input  stall_i,
        input  jmp_en,
        input  jmp_target,
        input  imem_rdata,
        output imem_addr,
        output curr_pc,
        output ACIns,
        output ins_valid,
        output flush_out
    );

    modport slave (
        output stall_i,
        output jmp_en,
        output jmp_target,
        output imem_rdata,
        input  imem_addr,
        input  curr_pc,
        input  ACIns,
        input  ins_valid,
        input  flush_out
    );

endinterface : fetch_pc_unit_if

// File: rtl/fetch_skid_reg.sv
// ---------------------------------------------------------------------------
// fetch_skid_reg
//   One-entry skid buffer holding a ROM word and its byte address while the
//   downstream stage stalls. Because the ROM has a fixed one-cycle latency,
//   the word returned during a stall must be parked here or it is lost.
//
//   clk, rst  clock / asynchronous active-low reset
//   clear     drop the entry and return contents to the bubble (redirect)
//   load      capture d_word/d_pc and mark the entry valid
//   drain     the held entry was accepted downstream; mark it invalid
//   d_word    incoming instruction word
//   d_pc      incoming instruction address
//   q_word    held instruction word
//   q_pc      held instruction address
//   q_valid   entry holds an instruction not yet accepted
// ---------------------------------------------------------------------------
module fetch_skid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic        drain,
    input  logic [31:0] d_word,
    input  logic [31:0] d_pc,
    output logic [31:0] q_word,
    output logic [31:0] q_pc,
    output logic        q_valid
);

    // NOTE: the data fields are reset as well as the valid bit, so that the
    // bubble word, not stale data, is what sits here after reset or redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            q_word  <= NOP_INSTR;
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (clear) begin
            q_word  <= NOP_INSTR;
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_word  <= d_word;
            q_pc    <= d_pc;
            q_valid <= 1'b1;
        end else if (drain) begin
            q_valid <= 1'b0;
        end
    end

endmodule : fetch_skid_reg

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   Program-counter and instruction-presentation stage in front of a
//   synchronous (1-cycle latency) instruction ROM. Keeps one instruction
//   per cycle flowing when unstalled, parks the in-flight ROM word in a skid
//   register on stall so nothing is lost or repeated, and redirects on jmp_en
//   with a two-cycle target-to-presentation latency.
//
//   Parameters
//     RESET_PC   first fetch address after reset
//     NOP_INSTR  bubble word presented while nothing valid is held
//   Ports
//     clk        single clock, all state on the rising edge
//     rst        asynchronous active-low reset
//     bus        fetch_pc_unit_if.master (control, ROM port, presented word)
// ---------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_pc_unit_if.master         bus
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] fetch_pc_q;   // address currently driven to the ROM
    logic [31:0] resp_pc_q;    // address whose data the ROM returns now

    logic        issue;
    logic        skid_load;
    logic        skid_drain;
    logic [31:0] skid_word;
    logic [31:0] skid_pc;
    logic        skid_valid;

    // -----------------------------------------------------------------------
    // Next-state logic
    // An issue launches a new ROM read. It is allowed whenever the current
    // presentation is being accepted, or when nothing is presented at all
    // (IDLE). A redirect always wins and suppresses the issue: the word it
    // would fetch lies on the squashed path.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through it leaves a variable unassigned (which would infer a latch).
        state_d    = state_q;
        issue      = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;

        if (bus.jmp_en) begin
            state_d = IDLE;
        end else begin
            issue = !bus.stall_i || (state_q == IDLE);

            // The ROM word arriving under a stall has no other home; park it.
            skid_load = bus.stall_i && (state_q == RESP);

            // Leaving HELD via an issue means the parked word was accepted.
            skid_drain = issue && (state_q == HELD);

            if (issue) begin
                state_d = RESP;
            end else if (state_q == RESP) begin
                state_d = HELD;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State and PC registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (bus.jmp_en) begin
                // Instructions are word aligned; the low two bits are dropped.
                fetch_pc_q <= bus.jmp_target & ~32'h3;
            end else if (issue) begin
                // 32-bit add wraps 32'hFFFF_FFFC to zero on its own.
                fetch_pc_q <= fetch_pc_q + PC_STEP;
                resp_pc_q  <= fetch_pc_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Skid entry: the only storage for a word the ROM has already returned.
    // -----------------------------------------------------------------------
    fetch_skid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.jmp_en),
        .load    (skid_load),
        .drain   (skid_drain),
        .d_word  (bus.imem_rdata),
        .d_pc    (resp_pc_q),
        .q_word  (skid_word),
        .q_pc    (skid_pc),
        .q_valid (skid_valid)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // The ROM address comes straight from a register, so there is no input
    // to imem_addr path. ins_valid and flush_out react to jmp_en in the same
    // cycle so the downstream register squashes the wrong-path instruction.
    // -----------------------------------------------------------------------
    assign bus.imem_addr = fetch_pc_q;

    always_comb begin
        bus.curr_pc   = resp_pc_q;
        bus.ACIns     = NOP_INSTR;
        bus.ins_valid = (state_q != IDLE) && !bus.jmp_en;
        bus.flush_out = bus.jmp_en;

        unique case (state_q)
            HELD: begin
                bus.curr_pc = skid_pc;
                bus.ACIns   = skid_word;
            end
            RESP: begin
                bus.curr_pc = resp_pc_q;
                bus.ACIns   = bus.imem_rdata;
            end
            default: begin
                // IDLE: bubble with the last response address.
            end
        endcase
    end

    // A word can live either in the skid register or on the ROM output,
    // never both; both set would mean one of them gets dropped.
    a_skid_resp_exclusive : assert property (
        @(posedge clk) disable iff (!rst)
        !(skid_valid && (state_q == RESP))
    );

endmodule : fetch_pc_unit
